// File: rtl/text_frame_queue_pkg.sv
// Shared types and constants for the text frame queue between min_os RX and TX.
package text_queue_pkg;

   localparam int unsigned TEXT_MAX_BYTES = 32;
   localparam int unsigned TEXT_BUS_W     = TEXT_MAX_BYTES * 8;
   localparam int unsigned SIZE_W         = 8;

   typedef logic [TEXT_BUS_W-1:0] text_bus_t;
   typedef logic [SIZE_W-1:0]     text_size_t;

   typedef struct packed {
      text_bus_t  bytes;
      text_size_t size;
   } frame_t;

   typedef enum logic [1:0] {IDLE, LOAD, PRESENT} tx_state_e;

   function automatic text_size_t clamp_size(input text_size_t size, input text_size_t max_size);
      return (size > max_size) ? max_size : size;
   endfunction

endpackage

// File: rtl/text_frame_queue_if.sv
// RX capture and TX valid/ready handshake signals of the text frame queue.
interface text_frame_queue_if;
   import text_queue_pkg::*;

   text_bus_t  rx_text_bytes;
   text_size_t rx_text_size;
   logic       rx_is_text_ready;
   text_bus_t  tx_text_bytes;
   text_size_t tx_text_size;
   logic       tx_text_valid;
   logic       tx_text_ready;

   // Environment side: drives RX and the TX ready.
   modport master (
      output rx_text_bytes, rx_text_size, rx_is_text_ready, tx_text_ready,
      input  tx_text_bytes, tx_text_size, tx_text_valid
   );

   // Queue side.
   modport slave (
      input  rx_text_bytes, rx_text_size, rx_is_text_ready, tx_text_ready,
      output tx_text_bytes, tx_text_size, tx_text_valid
   );

endinterface

// File: rtl/text_frame_queue_fifo.sv
// Circular frame store with extra-msb pointers and a read register loaded on pop.
module frame_fifo
   import text_queue_pkg::*;
#(
   parameter int unsigned Depth = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  frame_t                     wdata_i,
   input  logic                       pop_i,
   output frame_t                     rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(Depth):0]     level_o
);

   localparam int unsigned AddrW = $clog2(Depth);

   logic [AddrW:0] wr_ptr_q, rd_ptr_q;
   frame_t         rdata_q;
   frame_t         mem_q [Depth];
   logic           push_ok, pop_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
   assign level_o = wr_ptr_q - rd_ptr_q;
   assign rdata_o = rdata_q;

   assign pop_ok  = pop_i & ~empty_o;
   // A push into a full store is legal only when the head leaves in the same cycle.
   assign push_ok = push_i & (~full_o | pop_ok);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rdata_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            rdata_q  <= mem_q[rd_ptr_q[AddrW-1:0]];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/text_frame_queue.sv
// Edge-detected capture of min_os text frames into a queue, replayed to TX with
// valid/ready, plus byte/peek/drop statistics for the LED mux.
module text_frame_queue
   import text_queue_pkg::*;
#(
   parameter int unsigned MAX_BYTES = TEXT_MAX_BYTES,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   text_frame_queue_if.slave       txt,
   output logic [7:0]              byte_total,
   output logic [7:0]              peek_0,
   output logic [7:0]              peek_1,
   output logic [7:0]              peek_2,
   output logic [7:0]              drop_count,
   output logic [$clog2(DEPTH):0]  queue_level
);

   logic       ready_q;
   logic       frame_event, frame_valid, push, drop;
   logic       pop, load, tx_valid;
   logic       full, empty;
   text_size_t rx_size;
   frame_t     wr_frame, head;
   tx_state_e  state_q, state_d;
   text_bus_t  tx_bytes_q;
   text_size_t tx_size_q;
   logic [7:0] byte_total_q, peek_0_q, peek_1_q, peek_2_q, drop_count_q;

   assign frame_event    = txt.rx_is_text_ready & ~ready_q;
   assign rx_size        = clamp_size(txt.rx_text_size, text_size_t'(MAX_BYTES));
   assign frame_valid    = frame_event & (rx_size != '0);
   assign push           = frame_valid & (~full | pop);
   assign drop           = frame_valid & full & ~pop;
   assign wr_frame.bytes = txt.rx_text_bytes;
   assign wr_frame.size  = rx_size;

   frame_fifo #(
      .Depth (DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .push_i  (push),
      .wdata_i (wr_frame),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (queue_level)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ready_q      <= 1'b0;
         byte_total_q <= '0;
         peek_0_q     <= '0;
         peek_1_q     <= '0;
         peek_2_q     <= '0;
         drop_count_q <= '0;
      end else begin
         ready_q <= txt.rx_is_text_ready;
         if (push) begin
            byte_total_q <= byte_total_q + rx_size;
            peek_0_q     <= txt.rx_text_bytes[15:8];
            peek_1_q     <= txt.rx_text_bytes[23:16];
            peek_2_q     <= txt.rx_text_bytes[31:24];
         end
         if (drop && drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!empty) state_d = LOAD;
         LOAD:    state_d = PRESENT;
         PRESENT: if (txt.tx_text_ready) state_d = empty ? IDLE : LOAD;
         default: state_d = IDLE;
      endcase
   end

   // Pop one cycle ahead of LOAD so the fifo read register holds the head in LOAD.
   always_comb begin
      pop      = 1'b0;
      load     = 1'b0;
      tx_valid = 1'b0;
      unique case (state_q)
         IDLE:    pop = ~empty;
         LOAD:    load = 1'b1;
         PRESENT: begin
            tx_valid = 1'b1;
            pop      = txt.tx_text_ready & ~empty;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tx_bytes_q <= '0;
         tx_size_q  <= '0;
      end else if (load) begin
         tx_bytes_q <= head.bytes;
         tx_size_q  <= head.size;
      end
   end

   assign txt.tx_text_bytes = tx_bytes_q;
   assign txt.tx_text_size  = tx_size_q;
   assign txt.tx_text_valid = tx_valid;
   assign byte_total        = byte_total_q;
   assign peek_0            = peek_0_q;
   assign peek_1            = peek_1_q;
   assign peek_2            = peek_2_q;
   assign drop_count        = drop_count_q;

endmodule

// File: tb/tb_text_frame_queue.sv
// Directed bench for text_frame_queue: scoreboard of expected TX frames plus a
// reference model of the statistics outputs.
module tb_text_frame_queue;
   import text_queue_pkg::*;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;

   text_frame_queue_if bus ();

   logic [7:0] byte_total, peek_0, peek_1, peek_2, drop_count;
   logic [2:0] queue_level;

   text_frame_queue #(
      .MAX_BYTES (32),
      .DEPTH     (4)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .txt         (bus.slave),
      .byte_total  (byte_total),
      .peek_0      (peek_0),
      .peek_1      (peek_1),
      .peek_2      (peek_2),
      .drop_count  (drop_count),
      .queue_level (queue_level)
   );

   always #5 CLK = ~CLK;

   int         tests = 0;
   int         fails = 0;
   frame_t     sb[$];
   logic [7:0] exp_total = 0, exp_drop = 0, exp_p0 = 0, exp_p1 = 0, exp_p2 = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic text_bus_t rand_bytes();
      text_bus_t b;
      for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
      return b;
   endfunction

   task automatic check_stats(input string tag);
      check({tag, "_byte_total"}, byte_total, exp_total);
      check({tag, "_drop_count"}, drop_count, exp_drop);
      check({tag, "_peek_0"}, peek_0, exp_p0);
      check({tag, "_peek_1"}, peek_1, exp_p1);
      check({tag, "_peek_2"}, peek_2, exp_p2);
   endtask

   task automatic expect_frame(input text_bus_t b, input text_size_t sz);
      frame_t f;
      text_size_t csz;
      csz     = (sz > 8'd32) ? 8'd32 : sz;
      f.bytes = b;
      f.size  = csz;
      sb.push_back(f);
      exp_total = exp_total + csz;
      exp_p0    = b[15:8];
      exp_p1    = b[23:16];
      exp_p2    = b[31:24];
   endtask

   // Raise rx_is_text_ready for one cycle, then low; stats are checked after the edge.
   task automatic send(input text_bus_t b, input text_size_t sz, input bit accept,
                       input bit dropped);
      @(posedge CLK); #1;
      bus.rx_text_bytes    = b;
      bus.rx_text_size     = sz;
      bus.rx_is_text_ready = 1'b1;
      if (accept) expect_frame(b, sz);
      if (dropped && exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
      @(posedge CLK); #1;
      bus.rx_is_text_ready = 1'b0;
      check_stats("send");
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || queue_level != 0 || bus.tx_text_valid) && n < 300) begin
         @(posedge CLK); #1;
         n++;
      end
      check("drain_in_time", n < 300, 1);
   endtask

   // Output monitor: every handshake must match the head of the scoreboard.
   always @(negedge CLK) begin
      if (RST_N && bus.tx_text_valid && bus.tx_text_ready) begin
         check("frame_expected", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            frame_t f;
            f = sb.pop_front();
            check("tx_size", bus.tx_text_size, f.size);
            check("tx_bytes", bus.tx_text_bytes, f.bytes);
         end
      end
   end

   initial begin
      text_bus_t  b;
      text_size_t sz;
      logic [7:0] d;

      bus.rx_text_bytes    = '0;
      bus.rx_text_size     = '0;
      bus.rx_is_text_ready = 1'b0;
      bus.tx_text_ready    = 1'b0;

      // Reset values
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_valid", bus.tx_text_valid, 0);
      check("rst_level", queue_level, 0);
      check("rst_tx_size", bus.tx_text_size, 0);
      check("rst_tx_bytes", bus.tx_text_bytes, 0);
      check_stats("rst");
      RST_N = 1'b1;

      // Single "ABC" frame with latency check
      bus.tx_text_ready = 1'b1;
      b = '0;
      b[23:0] = 24'h434241;
      @(posedge CLK); #1;
      bus.rx_text_bytes    = b;
      bus.rx_text_size     = 8'd3;
      bus.rx_is_text_ready = 1'b1;
      expect_frame(b, 8'd3);
      @(posedge CLK); #1;
      bus.rx_is_text_ready = 1'b0;
      check("abc_valid_n1", bus.tx_text_valid, 0);
      check_stats("abc");
      @(posedge CLK); #1;
      check("abc_valid_n2", bus.tx_text_valid, 0);
      @(posedge CLK); #1;
      check("abc_valid_n3", bus.tx_text_valid, 1);
      check("abc_tx_size", bus.tx_text_size, 3);
      check("abc_tx_bytes", bus.tx_text_bytes[23:0], 24'h434241);
      check("abc_total", byte_total, 3);
      check("abc_peek_0", peek_0, 8'h42);
      wait_drain();

      // Oversize frame clamps to 32; data holds after the handshake
      send(rand_bytes(), 8'd40, 1'b1, 1'b0);
      wait_drain();
      check("clamp_tx_size_held", bus.tx_text_size, 32);

      // Zero-size event is ignored
      send(rand_bytes(), 8'd0, 1'b0, 1'b0);
      repeat (4) @(posedge CLK);
      #1;
      check("zero_level", queue_level, 0);
      check("zero_valid", bus.tx_text_valid, 0);

      // Back-pressure: first frame sits in PRESENT, four fill the fifo, rest drop
      bus.tx_text_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(rand_bytes(), 8'(i + 1), 1'b1, 1'b0);
      send(rand_bytes(), 8'd6, 1'b0, 1'b1);
      check("bp_level", queue_level, 4);
      check("bp_drop_1", drop_count, 1);
      send(rand_bytes(), 8'd7, 1'b0, 1'b1);
      check("bp_drop_2", drop_count, 2);
      bus.tx_text_ready = 1'b1;
      wait_drain();

      // Full queue with an event coinciding with a PRESENT->LOAD pop
      bus.tx_text_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(rand_bytes(), 8'd4, 1'b1, 1'b0);
      check("coinc_full_level", queue_level, 4);
      b = rand_bytes();
      @(posedge CLK); #1;
      bus.rx_text_bytes    = b;
      bus.rx_text_size     = 8'd9;
      bus.rx_is_text_ready = 1'b1;
      bus.tx_text_ready    = 1'b1;
      expect_frame(b, 8'd9);
      @(posedge CLK); #1;
      bus.rx_is_text_ready = 1'b0;
      bus.tx_text_ready    = 1'b0;
      check("coinc_level", queue_level, 4);
      check_stats("coinc");
      bus.tx_text_ready = 1'b1;
      wait_drain();

      // byte_total wraps modulo 256
      while (exp_total != 8'd250) begin
         d  = 8'd250 - exp_total;
         sz = (d > 8'd32) ? 8'd32 : d;
         send(rand_bytes(), sz, 1'b1, 1'b0);
      end
      check("wrap_pre_total", byte_total, 250);
      send(rand_bytes(), 8'd10, 1'b1, 1'b0);
      check("wrap_total", byte_total, 4);
      wait_drain();

      // drop_count saturates at 255
      bus.tx_text_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(rand_bytes(), 8'd2, 1'b1, 1'b0);
      for (int i = 0; i < 254; i++) send(rand_bytes(), 8'd5, 1'b0, 1'b1);
      check("sat_drop_255", drop_count, 255);
      send(rand_bytes(), 8'd5, 1'b0, 1'b1);
      check("sat_drop_hold", drop_count, 255);

      // Asynchronous reset while a frame is presented
      check("pre_rst_valid", bus.tx_text_valid, 1);
      @(posedge CLK); #1;
      RST_N = 1'b0;
      sb.delete();
      exp_total = 0;
      exp_drop  = 0;
      exp_p0    = 0;
      exp_p1    = 0;
      exp_p2    = 0;
      @(negedge CLK);
      check("mid_rst_valid", bus.tx_text_valid, 0);
      check("mid_rst_level", queue_level, 0);
      check("mid_rst_tx_size", bus.tx_text_size, 0);
      check_stats("mid_rst");
      RST_N = 1'b1;
      bus.tx_text_ready = 1'b1;
      repeat (5) @(posedge CLK);
      #1;
      check("post_rst_valid", bus.tx_text_valid, 0);
      check("post_rst_level", queue_level, 0);
      send(rand_bytes(), 8'd12, 1'b1, 1'b0);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
